udp_frame_sender: RTL and testbench

- Downstream stage of the test-frame generator; drains the dual-clock write FIFO on the UDP TX clock domain.
- Waits until one complete frame (FRAME_LEN bytes) is buffered, starts a UDP transmission of exactly FRAME_LEN bytes, then streams FIFO bytes on the core's per-byte requests.
- Checks the 16-bit little-endian frame sequence number in payload bytes 0–1 and keeps status counters.

---
 rtl/udp_frame_sender_pkg.sv | 31 +++
 rtl/udp_frame_sender_seq_checker.sv | 63 ++++++
 rtl/udp_frame_sender.sv | 154 +++++++++++++++
 tb/tb_udp_frame_sender.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_frame_sender_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | udp_frame_sender_pkg : shared frame constants and sender state encoding     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package udp_frame_sender_pkg;

  localparam int FRAME_LEN       = 1282;
  localparam int SEQ_MOD         = 480;
  localparam int IFG_CYC_DEF     = 64;
  localparam int TIMEOUT_CYC_DEF = 4096;
  localparam int BCNT_W          = $clog2(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_SEND      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5
  } state_t;

  // Successor of a received sequence number, wrapping at SEQ_MOD.
  function automatic logic [15:0] seq_next(input logic [15:0] rx);
    logic [16:0] w_sum;
    w_sum = {1'b0, rx} + 17'd1;
    return 16'(w_sum % 17'(SEQ_MOD));
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_frame_sender_seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | udp_frame_sender_seq_checker : checks the LE sequence number in bytes 0-1   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module udp_frame_sender_seq_checker
  import udp_frame_sender_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_vld,
  input  logic [BCNT_W-1:0] i_idx,
  input  logic [7:0]        i_data,
  output logic [15:0]       o_exp_seq,
  output logic              o_seq_valid,
  output logic [15:0]       o_seq_err_cnt
);

  logic [7:0]  r_lsb;
  logic        r_lsb_ok;
  logic [15:0] r_exp_seq;
  logic        r_seq_valid;
  logic [15:0] r_err_cnt;
  logic [15:0] w_rx;
  logic        w_chk;

  assign w_rx  = {i_data, r_lsb};
  // Only a header whose both bytes really came from the FIFO is checked.
  assign w_chk = i_vld && (i_idx == BCNT_W'(1)) && r_lsb_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsb       <= 8'h00;
      r_lsb_ok    <= 1'b0;
      r_exp_seq   <= 16'h0000;
      r_seq_valid <= 1'b0;
      r_err_cnt   <= 16'h0000;
    end else begin
      if (i_clr) begin
        r_lsb_ok <= 1'b0;
      end else if (i_vld && (i_idx == BCNT_W'(0))) begin
        r_lsb    <= i_data;
        r_lsb_ok <= 1'b1;
      end else if (i_vld) begin
        r_lsb_ok <= 1'b0;
      end

      if (w_chk) begin
        r_exp_seq   <= seq_next(w_rx);
        r_seq_valid <= 1'b1;
        if (r_seq_valid && (w_rx != r_exp_seq) && (r_err_cnt != 16'hFFFF))
          r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_exp_seq     = r_exp_seq;
  assign o_seq_valid   = r_seq_valid;
  assign o_seq_err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/udp_frame_sender.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | udp_frame_sender : drains one buffered frame per UDP packet, tracks status  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module udp_frame_sender
  import udp_frame_sender_pkg::*;
#(
  parameter int RDW_W       = 12,
  parameter int IFG_CYC     = IFG_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RDW_W-1:0] fifo_rdusedw,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  output logic             tx_start_en,
  output logic [15:0]      tx_byte_num,
  input  logic             tx_busy,
  input  logic             tx_req,
  output logic [7:0]       tx_data,
  input  logic             tx_done,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      seq_err_cnt,
  output logic [7:0]       timeout_cnt,
  output logic             underflow
);

  localparam int                TMR_W      = $clog2(((TIMEOUT_CYC > IFG_CYC) ? TIMEOUT_CYC : IFG_CYC) + 1);
  localparam logic [RDW_W-1:0]  C_LVL      = RDW_W'(FRAME_LEN);
  localparam logic [BCNT_W-1:0] C_LEN      = BCNT_W'(FRAME_LEN);
  localparam logic [TMR_W-1:0]  C_TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  C_IFG_LAST = TMR_W'(IFG_CYC - 1);

  state_t            r_state, w_next;
  logic [BCNT_W-1:0] r_byte_cnt;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_rd_vld;
  logic [BCNT_W-1:0] r_rd_idx;
  logic [15:0]       r_tx_byte_num;
  logic [15:0]       r_frame_cnt;
  logic [7:0]        r_timeout_cnt;
  logic              r_underflow;
  logic              w_req_ok, w_rd, w_tmo, w_done, w_gap_end;
  logic [15:0]       w_exp_seq_unused;
  logic              w_seq_valid_unused;

  always_comb begin
    w_next    = r_state;
    w_req_ok  = 1'b0;
    w_rd      = 1'b0;
    w_tmo     = 1'b0;
    w_done    = 1'b0;
    w_gap_end = 1'b0;
    case (r_state)
      S_IDLE:      if ((fifo_rdusedw >= C_LVL) && !tx_busy) w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_next = S_SEND;
        end else if (r_tmr == C_TMO_LAST) begin
          w_next = S_IDLE;
          w_tmo  = 1'b1;
        end
      end
      S_SEND: begin
        // Requests past the frame end are ignored; empty-FIFO requests still count.
        w_req_ok = tx_req && (r_byte_cnt < C_LEN);
        w_rd     = w_req_ok && !fifo_empty;
        if (tx_done) begin
          w_done = 1'b1;
          w_next = S_GAP;
        end else if (r_byte_cnt == C_LEN) begin
          w_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done) begin
          w_done = 1'b1;
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_tmr == C_IFG_LAST) begin
          w_next    = S_IDLE;
          w_gap_end = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_tmr         <= '0;
      r_rd_vld      <= 1'b0;
      r_rd_idx      <= '0;
      r_tx_byte_num <= 16'h0000;
      r_frame_cnt   <= 16'h0000;
      r_timeout_cnt <= 8'h00;
      r_underflow   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_rd_vld <= w_rd;
      r_rd_idx <= r_byte_cnt;

      if (w_next != r_state)
        r_tmr <= '0;
      else if ((r_state == S_WAIT_BUSY) || (r_state == S_GAP))
        r_tmr <= r_tmr + TMR_W'(1);

      if (w_gap_end)
        r_byte_cnt <= '0;
      else if (w_req_ok)
        r_byte_cnt <= r_byte_cnt + BCNT_W'(1);

      if ((r_state == S_IDLE) && (w_next == S_START))
        r_tx_byte_num <= 16'(FRAME_LEN);
      if (w_done)
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_tmo && (r_timeout_cnt != 8'hFF))
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      if (w_req_ok && fifo_empty)
        r_underflow <= 1'b1;
    end
  end

  udp_frame_sender_seq_checker u_seq_checker (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clr         (tx_start_en),
    .i_vld         (r_rd_vld),
    .i_idx         (r_rd_idx),
    .i_data        (fifo_rd_data),
    .o_exp_seq     (w_exp_seq_unused),
    .o_seq_valid   (w_seq_valid_unused),
    .o_seq_err_cnt (seq_err_cnt)
  );

  // Read data arrives one cycle after the request, exactly when the core wants it.
  assign tx_data     = r_rd_vld ? fifo_rd_data : 8'h00;
  assign fifo_rd_en  = w_rd;
  assign tx_start_en = (r_state == S_START);
  assign tx_byte_num = r_tx_byte_num;
  assign frame_cnt   = r_frame_cnt;
  assign timeout_cnt = r_timeout_cnt;
  assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_udp_frame_sender.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_udp_frame_sender : FIFO + UDP core models with a byte scoreboard         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_udp_frame_sender;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] fifo_rdusedw;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic        tx_busy = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic [15:0] frame_cnt;
  logic [15:0] seq_err_cnt;
  logic [7:0]  timeout_cnt;
  logic        underflow;

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  mem [0:65535];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          start_cnt = 0;
  int          cyc = 0;
  bit          lvl_ovr = 1'b0;
  logic [7:0]  sb_q [$];

  always #5 clk = ~clk;

  udp_frame_sender dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rdusedw (fifo_rdusedw),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_busy      (tx_busy),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .frame_cnt    (frame_cnt),
    .seq_err_cnt  (seq_err_cnt),
    .timeout_cnt  (timeout_cnt),
    .underflow    (underflow)
  );

  // Normal-mode FIFO: data appears the cycle after the read request.
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_rdusedw = lvl_ovr ? 12'd1282 : 12'(wr_ptr - rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start_en) start_cnt <= start_cnt + 1;
    if (fifo_rd_en) begin
      fifo_rd_data <= (rd_ptr < wr_ptr) ? mem[16'(rd_ptr)] : 8'hEE;
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Generator frame layout: LE sequence number, then 0x1F/0x00 alternating.
  task automatic push_bytes(input logic [15:0] seq, input int first, input int last);
    logic [7:0] b;
    for (int i = first; i <= last; i++) begin
      if (i == 0)          b = seq[7:0];
      else if (i == 1)     b = seq[15:8];
      else if (i % 2 == 0) b = 8'h1F;
      else                 b = 8'h00;
      mem[16'(wr_ptr + i - first)] = b;
      sb_q.push_back(b);
    end
    wr_ptr = wr_ptr + (last - first + 1);
  endtask

  task automatic wait_start(input int budget, input string tag, output int t);
    int n;
    n = 0;
    while (tx_start_en !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    n_total++;
    if (tx_start_en !== 1'b1) $display("FAIL %s start: tx_start_en=%b after %0d cycles, want 1", tag, tx_start_en, n);
    else n_pass++;
    n_total++;
    if (tx_byte_num !== 16'd1282) $display("FAIL %s byte_num: got %0d want 1282", tag, tx_byte_num);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (tx_start_en !== 1'b0) $display("FAIL %s start_width: tx_start_en=%b one cycle later, want 0", tag, tx_start_en);
    else n_pass++;
  endtask

  // UDP core model: n_req back-to-back requests; tx_done only for full packets.
  task automatic run_packet(input int n_req, input int exp_rd, input string tag);
    int rd0, bad, first_bad;
    logic [7:0] exp_b, got_b, want_b;
    rd0 = rd_ptr; bad = 0; first_bad = -1; got_b = 8'h00; want_b = 8'h00;
    tx_busy = 1'b1;
    for (int k = 0; k <= n_req; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'h00;
        if (tx_data !== exp_b) begin
          if (bad == 0) begin first_bad = k - 1; got_b = tx_data; want_b = exp_b; end
          bad++;
        end
      end
      tx_req = (k < n_req);
    end
    n_total++;
    if (bad != 0) $display("FAIL %s tx_data: %0d wrong bytes, first at %0d got %h want %h", tag, bad, first_bad, got_b, want_b);
    else n_pass++;
    n_total++;
    if ((rd_ptr - rd0) != exp_rd) $display("FAIL %s rd_count: got %0d want %0d", tag, rd_ptr - rd0, exp_rd);
    else n_pass++;
    if (n_req == 1282) begin
      tx_done = 1'b1;
      tx_busy = 1'b0;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_total++;
    if ({tx_start_en, fifo_rd_en, underflow} !== 3'b000)
      $display("FAIL %s flags: start/rd/underflow got %b want 000", tag, {tx_start_en, fifo_rd_en, underflow});
    else n_pass++;
    n_total++;
    if ({tx_byte_num, tx_data, timeout_cnt} !== 32'h0)
      $display("FAIL %s data: byte_num/tx_data/timeout got %h want 0", tag, {tx_byte_num, tx_data, timeout_cnt});
    else n_pass++;
    n_total++;
    if ({frame_cnt, seq_err_cnt} !== 32'h0)
      $display("FAIL %s counters: frame/seq_err got %h want 0", tag, {frame_cnt, seq_err_cnt});
    else n_pass++;
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) $display("FAIL %s: got %0d want %0d", tag, got, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_threshold();
    int t;
    push_bytes(16'd0, 0, 1280);
    repeat (100) @(negedge clk);
    check_cnt("thr_1281_no_start", 16'(start_cnt), 16'd0);
    check_cnt("thr_1281_no_read", 16'(rd_ptr), 16'd0);
    push_bytes(16'd0, 1281, 1281);
    wait_start(20, "thr_1282", t);
    check_cnt("thr_single_start", 16'(start_cnt), 16'd1);
    run_packet(1282, 1282, "thr_pkt");
  endtask

  task automatic test_back_to_back();
    int t;
    push_bytes(16'd1, 0, 1281);
    push_bytes(16'd2, 0, 1281);
    wait_start(200, "b2b_1", t);
    run_packet(1282, 1282, "b2b_pkt1");
    wait_start(200, "b2b_2", t);
    run_packet(1282, 1282, "b2b_pkt2");
    repeat (5) @(negedge clk);
    check_cnt("b2b_frame_cnt", frame_cnt, 16'd3);
    check_cnt("b2b_seq_err", seq_err_cnt, 16'd0);
  endtask

  task automatic test_wrap_and_error();
    int t;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_bytes(16'd478, 0, 1281);
    push_bytes(16'd479, 0, 1281);
    push_bytes(16'd0, 0, 1281);
    for (int p = 0; p < 3; p++) begin
      wait_start(200, "wrap", t);
      run_packet(1282, 1282, "wrap_pkt");
    end
    repeat (5) @(negedge clk);
    check_cnt("wrap_frame_cnt", frame_cnt, 16'd3);
    check_cnt("wrap_seq_err", seq_err_cnt, 16'd0);
    push_bytes(16'd5, 0, 1281);
    wait_start(200, "jump", t);
    run_packet(1282, 1282, "jump_pkt");
    repeat (5) @(negedge clk);
    check_cnt("jump_seq_err", seq_err_cnt, 16'd1);
    push_bytes(16'd6, 0, 1281);
    wait_start(200, "resync", t);
    run_packet(1282, 1282, "resync_pkt");
    repeat (5) @(negedge clk);
    check_cnt("resync_seq_err", seq_err_cnt, 16'd1);
  endtask

  task automatic test_timeout();
    int t0, t1;
    push_bytes(16'd7, 0, 1281);
    wait_start(200, "tmo_first", t0);
    repeat (4000) @(negedge clk);
    check_cnt("tmo_before", 16'(timeout_cnt), 16'd0);
    wait_start(300, "tmo_retry", t1);
    check_cnt("tmo_count", 16'(timeout_cnt), 16'd1);
    n_total++;
    if ((t1 - t0) < 4096 || (t1 - t0) > 4100)
      $display("FAIL tmo_retry_delay: got %0d cycles want 4096..4100", t1 - t0);
    else n_pass++;
    run_packet(1282, 1282, "tmo_pkt");
    repeat (5) @(negedge clk);
    check_cnt("tmo_frame_cnt", frame_cnt, 16'd6);
  endtask

  task automatic test_underflow();
    int t;
    check_cnt("uf_before", 16'(underflow), 16'd0);
    push_bytes(16'd8, 0, 699);
    lvl_ovr = 1'b1;
    wait_start(200, "uf", t);
    lvl_ovr = 1'b0;
    run_packet(1282, 700, "uf_pkt");
    repeat (5) @(negedge clk);
    check_cnt("uf_flag", 16'(underflow), 16'd1);
    check_cnt("uf_frame_cnt", frame_cnt, 16'd7);
    check_cnt("uf_seq_err", seq_err_cnt, 16'd1);
    push_bytes(16'd9, 0, 1281);
    wait_start(200, "uf_next", t);
    run_packet(1282, 1282, "uf_next_pkt");
    repeat (5) @(negedge clk);
    check_cnt("uf_next_seq_err", seq_err_cnt, 16'd1);
    check_cnt("uf_sticky", 16'(underflow), 16'd1);
  endtask

  task automatic test_reset_midpacket();
    int t, sc;
    push_bytes(16'd10, 0, 1281);
    push_bytes(16'd11, 0, 1281);
    push_bytes(16'd12, 0, 1281);
    wait_start(200, "mid", t);
    run_packet(300, 300, "mid_partial");
    rst_n = 1'b0;
    tx_busy = 1'b0;
    #1;
    check_idle_outputs("mid_async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wait_start(200, "mid_after1", t);
    run_packet(1282, 1282, "mid_pkt1");
    wait_start(200, "mid_after2", t);
    run_packet(1282, 1282, "mid_pkt2");
    sc = start_cnt;
    repeat (200) @(negedge clk);
    check_cnt("mid_frame_cnt", frame_cnt, 16'd2);
    n_total++;
    if (seq_err_cnt < 16'd1) $display("FAIL mid_seq_err: got %0d want >=1", seq_err_cnt);
    else n_pass++;
    check_cnt("mid_no_extra_start", 16'(start_cnt - sc), 16'd0);
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_back_to_back();
    test_wrap_and_error();
    test_timeout();
    test_underflow();
    test_reset_midpacket();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
